// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared state encoding, default digit count and BCD correction constants.
package seq_mult_pkg;
   typedef enum logic [1:0] {IDLE, MUL, CONV, DONE} state_t;
   localparam logic [3:0] DIGIT_TH  = 4'd5;
   localparam logic [3:0] DIGIT_ADD = 4'd3;
   function automatic int default_d(input int n);
      return (2 * n) / 3 + 1;
   endfunction
endpackage

// File: rtl/seq_bin2bcd.sv
// seq_bin2bcd: one double-dabble step per enabled edge, product bits shifted in MSB-first.
module seq_bin2bcd
   import seq_mult_pkg::*;
#(
   parameter int N = 8,
   parameter int D = default_d(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           step,
   input  logic           bit_in,
   output logic [4*D-1:0] bcd
);
   logic [4*D-1:0] adj;
   for (genvar g = 0; g < D; g++) begin : g_dig
      assign adj[4*g +: 4] = bcd[4*g +: 4] >= DIGIT_TH ? bcd[4*g +: 4] + DIGIT_ADD : bcd[4*g +: 4];
   end
   always_ff @(posedge clk) begin
      if (reset || load) bcd <= '0;
      else if (step) bcd <= {adj[4*D-2:0], bit_in};
   end
endmodule

// File: rtl/seq_mult_bcd.sv
// seq_mult_bcd: shift-add multiplier followed by iterative BCD conversion of the product.
// Define SEQ_MULT_SIGNED_EN to add two's-complement operands (signed_mode in, bcd_neg out).
module seq_mult_bcd
   import seq_mult_pkg::*;
#(
   parameter int N = 8,
   parameter int D = default_d(N)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   a_in,
   input  logic [N-1:0]   b_in,
`ifdef SEQ_MULT_SIGNED_EN
   input  logic           signed_mode,
   output logic           bcd_neg,
`endif
   input  logic           ack,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] out,
   output logic [4*D-1:0] bcd
);
   localparam int CW = $clog2(2 * N + 1);
   state_t state, state_nx;
   logic [2*N-1:0] sh, acc, res;
   logic [N-1:0] mult, a_mag, b_mag;
   logic [CW-1:0] cnt;
   logic last, load, step;
`ifdef SEQ_MULT_SIGNED_EN
   logic neg;
   assign a_mag = signed_mode && a_in[N-1] ? -a_in : a_in;
   assign b_mag = signed_mode && b_in[N-1] ? -b_in : b_in;
   assign res = neg ? -acc : acc;
`else
   assign a_mag = a_in;
   assign b_mag = b_in;
   assign res = acc;
`endif
   assign acc = out + (mult[0] ? sh : '0);
   assign last = cnt == CW'(1);
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      if (state == IDLE && start) state_nx = MUL;
      if (state == MUL && last) state_nx = CONV;
      if (state == CONV && last) state_nx = DONE;
      if (state == DONE && ack) state_nx = IDLE;
      busy = state != IDLE;
      done = state == DONE;
      load = state == IDLE && start;
      step = state == CONV;
   end
   // sh holds the shifted multiplicand during MUL, then the product magnitude fed to the converter
   always_ff @(posedge clk) begin
      if (reset) begin
         out  <= '0;
         sh   <= '0;
         mult <= '0;
         cnt  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         neg     <= 1'b0;
         bcd_neg <= 1'b0;
`endif
      end else if (load) begin
         out  <= '0;
         sh   <= {{N{1'b0}}, a_mag};
         mult <= b_mag;
         cnt  <= CW'(N);
`ifdef SEQ_MULT_SIGNED_EN
         neg     <= signed_mode && (a_in[N-1] ^ b_in[N-1]);
         bcd_neg <= 1'b0;
`endif
      end else if (state == MUL) begin
         out  <= last ? res : acc;
         sh   <= last ? acc : sh << 1;
         mult <= mult >> 1;
         cnt  <= last ? CW'(2 * N) : cnt - CW'(1);
`ifdef SEQ_MULT_SIGNED_EN
         if (last) bcd_neg <= neg && acc != '0;
`endif
      end else if (state == CONV) begin
         sh  <= sh << 1;
         cnt <= cnt - CW'(1);
      end
   end
   seq_bin2bcd #(.N(N), .D(D)) u_bcd (
      .clk(clk),
      .reset(reset),
      .load(load),
      .step(step),
      .bit_in(sh[2*N-1]),
      .bcd(bcd)
   );
endmodule
